// File: rtl/div_64b_iter_if.sv
// Handshake and operand/result bundle for the iterative unsigned divider.
// The master side issues a request; the slave side (the divider) returns results.
interface div_64b_iter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic             busy;
  logic             done;

  modport master (
    output start, in0, in1,
    input  out0, out1, busy, done
  );

  modport slave (
    input  start, in0, in1,
    output out0, out1, busy, done
  );
endinterface

// File: rtl/div_64b_iter.sv
// Unsigned WIDTH-bit restoring divider producing one quotient bit per clock.
// Fixed latency: done pulses in the cycle after the WIDTH-th iteration edge.
module div_64b_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  div_64b_iter_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] dvd, dvd_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] out0, out0_d;
  logic [WIDTH-1:0] out1, out1_d;
  logic             busy, busy_d;
  logic             done, done_d;

  // One shift-subtract step; the compare is WIDTH+1 bits wide so it cannot overflow.
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] dvd_step;

  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, dvs});
    // The true difference is below dvs, so modulo-2^WIDTH subtraction is exact.
    rem_step = rem_sh[WIDTH-1:0] - (ge ? dvs : '0);
    dvd_step = {dvd[WIDTH-2:0], ge};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    dvd_d   = dvd;
    dvs_d   = dvs;
    rem_d   = rem;
    cnt_d   = cnt;
    out0_d  = out0;
    out1_d  = out1;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.in0;
          dvs_d   = bus.in1;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        dvd_d = dvd_step;
        rem_d = rem_step;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          out0_d  = dvd_step;
          out1_d  = rem_step;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      out0  <= '0;
      out1  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      dvd   <= dvd_d;
      dvs   <= dvs_d;
      rem   <= rem_d;
      cnt   <= cnt_d;
      out0  <= out0_d;
      out1  <= out1_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  assign bus.out0 = out0;
  assign bus.out1 = out1;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_div_64b_iter.sv
// Directed and invariant-based checks for div_64b_iter: results, latency,
// handshake, ignored starts, divide-by-zero and mid-operation reset.
module tb_div_64b_iter;

  localparam int unsigned WIDTH = 64;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  div_64b_iter_if #(.WIDTH(WIDTH)) bus ();

  div_64b_iter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one division and return the cycle count from the start edge to done.
  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int cycles);
    bus.start = 1'b1;
    bus.in0   = a;
    bus.in1   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in0   = $urandom();
    bus.in1   = $urandom();
    cycles = 0;
    while (!bus.done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic div_check(input string tag, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] r);
    int cyc;
    run_div(a, b, cyc);
    check({tag, "_lat"}, 128'(cyc), 128'd64);
    check({tag, "_res"}, {bus.out1, bus.out0}, {r, q});
    check({tag, "_busy"}, 128'(bus.busy), 128'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 128'(bus.done), 128'd0);
    check({tag, "_hold"}, {bus.out1, bus.out0}, {r, q});
  endtask

  initial begin
    int cyc;
    int dones;
    logic [WIDTH-1:0] a, b;
    logic [127:0]     recon;

    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in0   = '0;
    bus.in1   = '0;
    #1;
    check("reset_state", {bus.out1, bus.out0}, 128'd0);
    check("reset_flags", {126'd0, bus.busy, bus.done}, 128'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    div_check("d100_7",   64'd100, 64'd7, 64'd14, 64'd2);
    div_check("dmax_1",   ONES, 64'd1, ONES, 64'd0);
    div_check("d12345_0", 64'd12345, 64'd0, ONES, 64'd12345);
    div_check("d5_10",    64'd5, 64'd10, 64'd0, 64'd5);
    div_check("d2p63_3",  64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2);

    // busy rises on the edge that samples start
    bus.start = 1'b1;
    bus.in0   = 64'd1000;
    bus.in1   = 64'd33;
    @(posedge clk); #1;
    check("busy_rise", 128'(bus.busy), 128'd1);
    bus.start = 1'b0;
    // a second start in the middle of the run must be ignored
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.in0   = 64'd7;
    bus.in1   = 64'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc   = 10;
    dones = 0;
    while (cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) dones++;
      if (cyc == 63) check("no_early_done", 128'(dones), 128'd0);
    end
    check("ign_done_at64", 128'(bus.done), 128'd1);
    check("ign_res", {bus.out1, bus.out0}, {64'd10, 64'd30});
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("ign_single_done", 128'(dones), 128'd1);

    // start held high across completion begins a new division
    bus.start = 1'b1;
    bus.in0   = 64'd5;
    bus.in1   = 64'd10;
    run_div(64'd5, 64'd10, cyc);
    check("hold_first", {bus.out1, bus.out0}, {64'd5, 64'd0});
    bus.start = 1'b1;
    bus.in0   = 64'h8000_0000_0000_0000;
    bus.in1   = 64'd3;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (bus.busy) bus.start = 1'b0;
    end while (!bus.done && cyc < 200);
    check("hold_restart_gap", 128'(cyc), 128'd66);
    check("hold_second", {bus.out1, bus.out0}, {64'd2, 64'h2AAA_AAAA_AAAA_AAAA});

    // asynchronous reset at cycle 30 of a run aborts it
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in0   = 64'd999;
    bus.in1   = 64'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {bus.out1, bus.out0}, 128'd0);
    check("mid_rst_flags", {126'd0, bus.busy, bus.done}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    check("mid_rst_quiet", 128'(dones), 128'd0);
    div_check("after_rst", 64'd999, 64'd4, 64'd249, 64'd3);

    // random operands checked against the division identity
    for (int i = 0; i < 24; i++) begin
      a = {$urandom(), $urandom()};
      b = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom() >> (i % 32), $urandom()};
      if (b == '0) b = 64'd1;
      run_div(a, b, cyc);
      recon = 128'(bus.out0) * 128'(b) + 128'(bus.out1);
      $display("rand %0d: {out1,out0}=%032h", i, {bus.out1, bus.out0});
      check("rand_lat", 128'(cyc), 128'd64);
      check("rand_identity", recon, 128'(a));
      check("rand_rem_lt", 128'(bus.out1 < b), 128'd1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
